// File: rtl/fc_argmax_classifier_pkg.sv
// Shared definitions for the FC argmax classifier: FP32 field positions,
// the collect/hold state encoding and a NaN detect helper.
package fc_argmax_classifier_pkg;

    localparam int FP_SIGN_BIT = 31;
    localparam int FP_EXP_MSB  = 30;
    localparam int FP_EXP_LSB  = 23;
    localparam int FP_MAN_MSB  = 22;
    localparam int FP_MAN_LSB  = 0;

    localparam logic [7:0] FP_EXP_ALL_ONES = 8'hFF;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } state_e;

    function automatic logic fp32_is_nan(input logic [31:0] v);
        return (v[FP_EXP_MSB:FP_EXP_LSB] == FP_EXP_ALL_ONES) &&
               (v[FP_MAN_MSB:FP_MAN_LSB] != '0);
    endfunction

endpackage

// File: rtl/fc_argmax_classifier_fp32_greater_than.sv
// Combinational FP32 "a > b" for the running-max update.
// Ports: a (candidate), b (current max), gt (a replaces b).
// NaN candidates never win; a NaN current max loses to any non-NaN; -0 == +0.
module fp32_greater_than
    import fc_argmax_classifier_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        gt
);

    logic a_nan;
    logic b_nan;
    logic both_zero;
    logic mag_gt;
    logic mag_lt;

    assign a_nan     = fp32_is_nan(a);
    assign b_nan     = fp32_is_nan(b);
    assign both_zero = (a[FP_EXP_MSB:0] == '0) && (b[FP_EXP_MSB:0] == '0);
    assign mag_gt    = a[FP_EXP_MSB:0] > b[FP_EXP_MSB:0];
    assign mag_lt    = a[FP_EXP_MSB:0] < b[FP_EXP_MSB:0];

    // Sign-magnitude ordering: for negatives the smaller magnitude is larger.
    always_comb begin
        gt = 1'b0;
        if (a_nan) begin
            gt = 1'b0;
        end else if (b_nan) begin
            gt = 1'b1;
        end else if (both_zero) begin
            gt = 1'b0;
        end else if (a[FP_SIGN_BIT] != b[FP_SIGN_BIT]) begin
            gt = ~a[FP_SIGN_BIT];
        end else if (!a[FP_SIGN_BIT]) begin
            gt = mag_gt;
        end else begin
            gt = mag_lt;
        end
    end

endmodule

// File: rtl/fc_argmax_classifier.sv
// Argmax over one vector of FP32 class scores from a fully connected layer.
// Ports: clk, rst_n (async, active-high), i_valid/i_data/o_ready score input,
// o_valid/o_class/o_score/i_ready result output; o_nan when
// FC_ARGMAX_NAN_FLAG_EN is defined.
module fc_argmax_classifier
    import fc_argmax_classifier_pkg::*;
#(
    parameter  int DATA_WIDTH        = 32,
    parameter  int NUMBER_INPUT_NODE = 2,
    localparam int INDEX_WIDTH       = (NUMBER_INPUT_NODE > 1) ?
                                       $clog2(NUMBER_INPUT_NODE) : 1
)(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_valid,
    input  logic [DATA_WIDTH-1:0]  i_data,
    output logic                   o_ready,
    output logic                   o_valid,
    output logic [INDEX_WIDTH-1:0] o_class,
    output logic [DATA_WIDTH-1:0]  o_score,
`ifdef FC_ARGMAX_NAN_FLAG_EN
    output logic                   o_nan,
`endif
    input  logic                   i_ready
);

    localparam logic [INDEX_WIDTH-1:0] LAST_CNT =
        INDEX_WIDTH'(NUMBER_INPUT_NODE - 1);

    state_e                 state_q, state_d;
    logic [INDEX_WIDTH-1:0] cnt_q, cnt_d;
    logic [INDEX_WIDTH-1:0] idx_q, idx_d;
    logic [DATA_WIDTH-1:0]  max_q, max_d;
    logic                   ready_q, ready_d;
    logic                   accept;
    logic                   new_gt;

    fp32_greater_than u_gt (
        .a  (i_data),
        .b  (max_q),
        .gt (new_gt)
    );

    // ready_q keeps o_ready low during reset and the first cycle after it.
    assign o_ready = (state_q == ST_COLLECT) && ready_q;
    assign o_valid = (state_q == ST_HOLD);
    assign o_class = idx_q;
    assign o_score = max_q;
    assign accept  = i_valid && o_ready;
    assign ready_d = 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        max_d   = max_q;
        unique case (state_q)
            ST_COLLECT: begin
                if (accept) begin
                    // First element seeds the max; later ones must be strictly greater.
                    if ((cnt_q == '0) || new_gt) begin
                        max_d = i_data;
                        idx_d = cnt_q;
                    end
                    if (cnt_q == LAST_CNT) begin
                        cnt_d   = '0;
                        state_d = ST_HOLD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (i_valid && i_ready) begin
                    state_d = ST_COLLECT;
                end
            end
            default: state_d = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= ST_COLLECT;
            cnt_q   <= '0;
            idx_q   <= '0;
            max_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            max_q   <= max_d;
            ready_q <= ready_d;
        end
    end

`ifdef FC_ARGMAX_NAN_FLAG_EN
    logic nan_q, nan_d;

    always_comb begin
        nan_d = nan_q;
        if (accept) begin
            nan_d = nan_q | fp32_is_nan(i_data[31:0]);
        end else if ((state_q == ST_HOLD) && i_valid && i_ready) begin
            nan_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            nan_q <= 1'b0;
        end else begin
            nan_q <= nan_d;
        end
    end

    assign o_nan = nan_q;
`endif

endmodule
